ifetch_ctrl: RTL and testbench
==============================

# ifetch_ctrl

Instruction fetch controller sequencing the single-cycle combinational instruction memory of the RV32I core. It owns the fetch PC, drives the memory address, and buffers fetched words in a small FIFO. It presents the buffered words to decode over a valid/ready handshake, and handles branch/jump redirects and halt requests from the execute stage.

## Interface
- `RESET_PC`, 32'h0000_0000: fetch PC loaded on reset.
- `DEPTH`, 2: instruction buffer entries; power of two, 2..8.
- `clk_i`  in  1  core clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset; one clock, synchronous, active-low.
- `imem_addr_o`  out  32  byte address to the instruction memory; always equals `fetch_pc`.
- `imem_instr_i`  in  32  instruction word; valid in the same cycle as `imem_addr_o`.
- `redirect_i`  in  1  taken branch/jump; flushes the buffer and reloads the PC.
- `redirect_pc_i`  in  32  redirect target byte address.
- `halt_i`  in  1  suspend fetching (level); buffered entries still drain.
- `out_valid_o`  out  1  buffer head valid.
- `out_ready_i`  in  1  decode accepts the head this cycle.
- `out_instr_o`  out  32  head instruction; 32'h0000_0013 (NOP) when not valid.
- `out_pc_o`  out  32  head PC; 32'h0 when not valid.
- `misalign_o`  out  1  trap flag; exists only with `IFETCH_ALIGN_CHECK_EN`.

## Operation
- **States:** FETCH, HALT, TRAP. TRAP exists only with the macro. Reset enters FETCH.
- **FETCH:**
  - push = !full || pop, where pop = out_valid_o && out_ready_i.
  - On push: enqueue {fetch_pc, imem_instr_i}, then fetch_pc += 4.
  - fetch_pc wraps modulo 2^32: 0xFFFF_FFFC advances to 0x0000_0000.
- **halt_i = 1** in FETCH moves to HALT at the next edge. No push occurs in that cycle.
- **HALT:**
  - No pushes; pops continue.
  - halt_i = 0 returns to FETCH. The first push occurs in the following cycle.
- **Redirect:** redirect_i has priority over everything.
  - At the edge: buffer cleared (count = 0, pointers reset), fetch_pc ← target, no push, and any pop that cycle is discarded.
  - The state goes to FETCH, or to HALT if halt_i = 1.
- **Redirect target alignment:** without the macro, redirect_pc_i[1:0] is ignored and treated as 2'b00.
- **Full/empty:**
  - Push and pop in the same cycle are legal when full or non-empty; count is unchanged.
  - Pop when empty is impossible because out_valid_o = 0.
- **Outputs** are driven directly from the buffer head registers (no combinational path from imem_instr_i).

## Timing
- **Reset values:** fetch_pc = RESET_PC, count = 0, out_valid_o = 0, out_instr_o = NOP, out_pc_o = 0, misalign_o = 0, state FETCH.
- **Latency:** an instruction fetched in cycle N appears on out_* in cycle N+1.
- **After rst_ni rises:**
  - Cycle 0: imem_addr_o = RESET_PC and a push occurs.
  - Cycle 1: out_valid_o = 1.
- **Redirect:**
  - Redirect asserted in cycle N: out_valid_o = 0 in N+1.
  - Target is fetched in N+1 and becomes valid in N+2 (2-cycle bubble).
- **Sustained throughput** is 1 instruction/cycle while out_ready_i = 1.
- **Reset mid-operation** discards all buffered entries; rst_ni has priority over redirect_i.
- **Handshake:** out_* are stable while out_valid_o && !out_ready_i, unless redirect_i is asserted.

## Configuration
- **IFETCH_ALIGN_CHECK_EN defined:**
  - A redirect with redirect_pc_i[1:0] != 0 flushes the buffer and enters TRAP, and latches the target into out_pc_o.
  - In TRAP: misalign_o = 1, no pushes, out_valid_o = 0.
  - TRAP is left only on an aligned redirect (to FETCH) or on reset.
- **Undefined:** the low two target bits are forced to 0, there is no TRAP state, and misalign_o is absent.

## Structure
- `ifetch_pkg` holds:
  - the state enum `ifetch_state_e`;
  - the `ifetch_entry_t` struct {pc[31:0], instr[31:0]};
  - the `INSTR_NOP` and `PC_STEP` (4) constants.
- One sub-module, `ifetch_fifo`: parameterized DEPTH, synchronous clear, with push/pop/full/empty and head output.
- The PC register, FSM and redirect logic stay in `ifetch_ctrl`.

## Test plan
- **Reset then free-run:** release reset with RESET_PC = 0 and out_ready_i = 1 → out_pc_o = 0x0, 0x4, 0x8 on consecutive cycles, and out_instr_o matches the memory words.
- **Backpressure:** out_ready_i = 0 for 5 cycles → count saturates at DEPTH, imem_addr_o holds at 0x8, and the head stays at pc 0x0. Then ready = 1 → pcs continue 0x4, 0x8 with no gaps or duplicates.
- **Redirect:** redirect_i with target 0x100 while the buffer is full → next cycle out_valid_o = 0, the following cycle out_pc_o = 0x100, and none of the older entries appear.
- **Halt:** halt_i = 1 for 3 cycles → the buffer drains and imem_addr_o stays frozen. Deassert → fetching resumes at the frozen address.
- **Wrap:** redirect to 0xFFFF_FFFC → outputs show pc 0xFFFF_FFFC followed by 0x0000_0000.
- **Misaligned target** (redirect to 0x102):
  - With the macro: misalign_o = 1, out_valid_o = 0 until a redirect to 0x104 clears the trap.
  - Without the macro: out_pc_o = 0x100.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package ifetch_pkg;

  // FSM state encoding; StTrap is only reachable when IFETCH_ALIGN_CHECK_EN is defined.
  typedef logic [1:0] ifetch_state_e;
  localparam ifetch_state_e StFetch = 2'd0;
  localparam ifetch_state_e StHalt  = 2'd1;
  localparam ifetch_state_e StTrap  = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifetch_entry_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Word-align a byte address.
  function automatic logic [31:0] align_pc(logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Fetch-side bus: instruction memory port, redirect/halt from execute, decode handshake.
// misalign_o exists only when IFETCH_ALIGN_CHECK_EN is defined.
interface ifetch_ctrl_if;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        halt_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_instr_o;
  logic [31:0] out_pc_o;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        misalign_o;
`endif

  // Fetch controller side.
  modport master (
    output imem_addr_o, out_valid_o, out_instr_o, out_pc_o,
`ifdef IFETCH_ALIGN_CHECK_EN
    output misalign_o,
`endif
    input  imem_instr_i, redirect_i, redirect_pc_i, halt_i, out_ready_i
  );

  // Memory / execute / decode side.
  modport slave (
    input  imem_addr_o, out_valid_o, out_instr_o, out_pc_o,
`ifdef IFETCH_ALIGN_CHECK_EN
    input  misalign_o,
`endif
    output imem_instr_i, redirect_i, redirect_pc_i, halt_i, out_ready_i
  );
endinterface

// File: rtl/ifetch_fifo.sv
// Instruction buffer: DEPTH-entry ring FIFO with synchronous clear and registered head.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  ifetch_entry_t data_i,
  output ifetch_entry_t head_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  ifetch_entry_t            mem_q [DEPTH];
  ifetch_entry_t            mem_d [DEPTH];
  logic          [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic          [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic          [CntW-1:0] count_q, count_d;
  logic                     do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Next-state: clear wins; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    do_push  = push_i && (!full_o || pop_i);
    do_pop   = pop_i && !empty_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, FSM and redirect handling, and
// buffers fetched words in ifetch_fifo for decode.
// Optional feature macro: IFETCH_ALIGN_CHECK_EN (misaligned redirects trap).
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic          clk_i,
  input logic          rst_ni,
  ifetch_ctrl_if.master fetch_io
);

  ifetch_state_e state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   target_pc;
  ifetch_entry_t head;
  logic          full, empty;
  logic          push, pop, clear;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic [31:0]   trap_pc_q, trap_pc_d;
`endif

  assign target_pc = align_pc(fetch_io.redirect_pc_i);
  assign pop       = !empty && fetch_io.out_ready_i;

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  ('{pc: fetch_pc_q, instr: fetch_io.imem_instr_i}),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Next-state: redirect overrides halt and normal fetching.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    clear      = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    trap_pc_d  = trap_pc_q;
`endif
    if (fetch_io.redirect_i) begin
      clear      = 1'b1;
      fetch_pc_d = target_pc;
      state_d    = fetch_io.halt_i ? StHalt : StFetch;
`ifdef IFETCH_ALIGN_CHECK_EN
      if (fetch_io.redirect_pc_i[1:0] != 2'b00) begin
        state_d   = StTrap;
        trap_pc_d = fetch_io.redirect_pc_i;
      end
`endif
    end else begin
      case (state_q)
        StFetch: begin
          if (fetch_io.halt_i) begin
            state_d = StHalt;
          end else if (!full || pop) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_STEP;
          end
        end
        StHalt: begin
          if (!fetch_io.halt_i) begin
            state_d = StFetch;
          end
        end
`ifdef IFETCH_ALIGN_CHECK_EN
        StTrap: state_d = StTrap;
`endif
        default: state_d = StFetch;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StFetch;
      fetch_pc_q <= RESET_PC;
`ifdef IFETCH_ALIGN_CHECK_EN
      trap_pc_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
`ifdef IFETCH_ALIGN_CHECK_EN
      trap_pc_q  <= trap_pc_d;
`endif
    end
  end

  // Outputs come from the buffer head registers; NOP/zero when nothing is valid.
  always_comb begin
    fetch_io.imem_addr_o = fetch_pc_q;
    fetch_io.out_valid_o = !empty;
    fetch_io.out_instr_o = empty ? INSTR_NOP : head.instr;
    fetch_io.out_pc_o    = empty ? 32'h0 : head.pc;
`ifdef IFETCH_ALIGN_CHECK_EN
    fetch_io.misalign_o  = (state_q == StTrap);
    if (state_q == StTrap) begin
      fetch_io.out_pc_o = trap_pc_q;
    end
`endif
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed self-checking bench for ifetch_ctrl (DEPTH = 2, RESET_PC = 0).
module tb_ifetch_ctrl;
  import ifetch_pkg::*;

  logic clk;
  logic rst_ni;
  int   n_vec;
  int   n_err;

  ifetch_ctrl_if bus ();

  ifetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .fetch_io (bus)
  );

  // Memory content pattern, distinct from NOP for every address.
  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A00_0000;
  endfunction

  assign bus.imem_instr_i = mem_word(bus.imem_addr_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.halt_i = 1'b0;
    bus.out_ready_i = 1'b1;
    step();
    step();
    n_vec++;
    if (bus.out_valid_o !== 1'b0) begin
      n_err++; $display("FAIL reset_valid got %h want 0", bus.out_valid_o);
    end
    n_vec++;
    if (bus.out_instr_o !== 32'h0000_0013) begin
      n_err++; $display("FAIL reset_instr got %h want 00000013", bus.out_instr_o);
    end
    n_vec++;
    if (bus.out_pc_o !== 32'h0) begin
      n_err++; $display("FAIL reset_pc got %h want 0", bus.out_pc_o);
    end
`ifdef IFETCH_ALIGN_CHECK_EN
    n_vec++;
    if (bus.misalign_o !== 1'b0) begin
      n_err++; $display("FAIL reset_misalign got %h want 0", bus.misalign_o);
    end
`endif
    rst_ni = 1'b1;
    #1;
    n_vec++;
    if (bus.imem_addr_o !== 32'h0) begin
      n_err++; $display("FAIL reset_addr got %h want 0", bus.imem_addr_o);
    end
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (bus.out_valid_o !== 1'b1 || bus.out_pc_o !== 32'(4 * i) ||
          bus.out_instr_o !== mem_word(32'(4 * i))) begin
        n_err++;
        $display("FAIL free_run[%0d] got v=%h pc=%h ins=%h want v=1 pc=%h ins=%h", i,
                 bus.out_valid_o, bus.out_pc_o, bus.out_instr_o, 32'(4 * i),
                 mem_word(32'(4 * i)));
      end
    end
  endtask

  task automatic test_backpressure();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i >= 1) begin
        n_vec++;
        if (bus.imem_addr_o !== 32'h8 || bus.out_valid_o !== 1'b1 || bus.out_pc_o !== 32'h0 ||
            bus.out_instr_o !== mem_word(32'h0)) begin
          n_err++;
          $display("FAIL backpressure_hold[%0d] got addr=%h v=%h pc=%h ins=%h want 8/1/0/%h",
                   i, bus.imem_addr_o, bus.out_valid_o, bus.out_pc_o, bus.out_instr_o,
                   mem_word(32'h0));
        end
      end
    end
    bus.out_ready_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      n_vec++;
      if (bus.out_valid_o !== 1'b1 || bus.out_pc_o !== 32'(4 * i)) begin
        n_err++;
        $display("FAIL backpressure_resume[%0d] got v=%h pc=%h want v=1 pc=%h", i,
                 bus.out_valid_o, bus.out_pc_o, 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect();
    bus.out_ready_i = 1'b0;
    step();
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h100;
    bus.out_ready_i = 1'b1;
    step();
    bus.redirect_i = 1'b0;
    n_vec++;
    if (bus.out_valid_o !== 1'b0 || bus.imem_addr_o !== 32'h100) begin
      n_err++;
      $display("FAIL redirect_bubble got v=%h addr=%h want v=0 addr=100", bus.out_valid_o,
               bus.imem_addr_o);
    end
    step();
    n_vec++;
    if (bus.out_valid_o !== 1'b1 || bus.out_pc_o !== 32'h100 ||
        bus.out_instr_o !== mem_word(32'h100)) begin
      n_err++;
      $display("FAIL redirect_target got v=%h pc=%h ins=%h want v=1 pc=100 ins=%h",
               bus.out_valid_o, bus.out_pc_o, bus.out_instr_o, mem_word(32'h100));
    end
    step();
    n_vec++;
    if (bus.out_valid_o !== 1'b1 || bus.out_pc_o !== 32'h104) begin
      n_err++;
      $display("FAIL redirect_next got v=%h pc=%h want v=1 pc=104", bus.out_valid_o,
               bus.out_pc_o);
    end
  endtask

  task automatic test_halt();
    logic [31:0] exp_pc [5];
    logic        exp_v  [5];
    exp_pc = '{32'h108, 32'h0, 32'h0, 32'h0, 32'h10C};
    exp_v  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    bus.out_ready_i = 1'b0;
    step();
    bus.halt_i = 1'b1;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) bus.halt_i = 1'b0;
      step();
      n_vec++;
      if (bus.out_valid_o !== exp_v[i] || bus.out_pc_o !== exp_pc[i] ||
          bus.imem_addr_o !== ((i == 4) ? 32'h110 : 32'h10C)) begin
        n_err++;
        $display("FAIL halt[%0d] got v=%h pc=%h addr=%h want v=%h pc=%h addr=%h", i,
                 bus.out_valid_o, bus.out_pc_o, bus.imem_addr_o, exp_v[i], exp_pc[i],
                 (i == 4) ? 32'h110 : 32'h10C);
      end
    end
  endtask

  task automatic test_wrap();
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFFC;
    step();
    bus.redirect_i = 1'b0;
    n_vec++;
    if (bus.out_valid_o !== 1'b0 || bus.imem_addr_o !== 32'hFFFF_FFFC) begin
      n_err++;
      $display("FAIL wrap_bubble got v=%h addr=%h want v=0 addr=fffffffc", bus.out_valid_o,
               bus.imem_addr_o);
    end
    step();
    n_vec++;
    if (bus.out_pc_o !== 32'hFFFF_FFFC || bus.imem_addr_o !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_last got pc=%h addr=%h want pc=fffffffc addr=0", bus.out_pc_o,
               bus.imem_addr_o);
    end
    step();
    n_vec++;
    if (bus.out_valid_o !== 1'b1 || bus.out_pc_o !== 32'h0 ||
        bus.out_instr_o !== mem_word(32'h0)) begin
      n_err++;
      $display("FAIL wrap_zero got v=%h pc=%h ins=%h want v=1 pc=0 ins=%h", bus.out_valid_o,
               bus.out_pc_o, bus.out_instr_o, mem_word(32'h0));
    end
  endtask

  task automatic test_misalign();
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h102;
    step();
    bus.redirect_i = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      n_vec++;
      if (bus.misalign_o !== 1'b1 || bus.out_valid_o !== 1'b0 || bus.out_pc_o !== 32'h102) begin
        n_err++;
        $display("FAIL misalign_trap[%0d] got m=%h v=%h pc=%h want m=1 v=0 pc=102", i,
                 bus.misalign_o, bus.out_valid_o, bus.out_pc_o);
      end
    end
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h104;
    step();
    bus.redirect_i = 1'b0;
    n_vec++;
    if (bus.misalign_o !== 1'b0 || bus.out_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL misalign_clear got m=%h v=%h want m=0 v=0", bus.misalign_o,
               bus.out_valid_o);
    end
    step();
    n_vec++;
    if (bus.out_valid_o !== 1'b1 || bus.out_pc_o !== 32'h104) begin
      n_err++;
      $display("FAIL misalign_resume got v=%h pc=%h want v=1 pc=104", bus.out_valid_o,
               bus.out_pc_o);
    end
`else
    n_vec++;
    if (bus.out_valid_o !== 1'b0 || bus.imem_addr_o !== 32'h100) begin
      n_err++;
      $display("FAIL misalign_addr got v=%h addr=%h want v=0 addr=100", bus.out_valid_o,
               bus.imem_addr_o);
    end
    step();
    n_vec++;
    if (bus.out_valid_o !== 1'b1 || bus.out_pc_o !== 32'h100) begin
      n_err++;
      $display("FAIL misalign_forced got v=%h pc=%h want v=1 pc=100", bus.out_valid_o,
               bus.out_pc_o);
    end
`endif
  endtask

  task automatic test_reset_mid();
    bus.out_ready_i = 1'b0;
    step();
    step();
    rst_ni = 1'b0;
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h200;
    step();
    n_vec++;
    if (bus.out_valid_o !== 1'b0 || bus.out_pc_o !== 32'h0 || bus.imem_addr_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mid got v=%h pc=%h addr=%h want 0/0/0", bus.out_valid_o,
               bus.out_pc_o, bus.imem_addr_o);
    end
    rst_ni = 1'b1;
    bus.redirect_i = 1'b0;
    bus.out_ready_i = 1'b1;
    step();
    n_vec++;
    if (bus.out_valid_o !== 1'b1 || bus.out_pc_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mid_refetch got v=%h pc=%h want v=1 pc=0", bus.out_valid_o,
               bus.out_pc_o);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_free_run();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_misalign();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
